// File: rtl/multicycle_ctrl.sv
// Multicycle instruction-sequencing controller.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction, issues the
// datapath strobes and counts retired instructions.
// Optional feature: define ILLEGAL_TRAP_EN to halt in TRAP on an unknown
// opcode; otherwise unknown opcodes retire as NOPs and Trap is tied low.
//
// state  | meaning
// FETCH  | instruction read on the shared memory port, wait for mem_ready
// DECODE | one-cycle opcode classification
// EXEC   | ALU cycle; branches retire here
// MEM    | data access on the shared port; stores retire here
// WB     | register file write-back, retire
// TRAP   | illegal opcode halt, left only by rst
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  OpCode,
  input  logic        mem_ready,
  output logic        MemReq,
  output logic        MemIsData,
  output logic        IRWr,
  output logic        PCWr,
  output logic        RUWr,
  output logic        DMWr,
  output logic [2:0]  State,
  output logic [31:0] Instret,
  output logic        Trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;
  logic        legal;
  logic        is_load, is_store, is_branch;

  // Opcode classification
  always_comb begin
    legal = 1'b0;
    case (OpCode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    is_load   = (OpCode == OP_LOAD);
    is_store  = (OpCode == OP_STORE);
    is_branch = (OpCode == OP_BRANCH);
  end

  // Next-state and strobe decode; rst masks every strobe in the reset cycle
  always_comb begin
    state_d   = state_q;
    MemReq    = 1'b0;
    MemIsData = 1'b0;
    IRWr      = 1'b0;
    PCWr      = 1'b0;
    RUWr      = 1'b0;
    DMWr      = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemReq = 1'b1;
        if (mem_ready) begin
          IRWr    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          PCWr    = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          PCWr    = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        MemReq    = 1'b1;
        MemIsData = 1'b1;
        DMWr      = is_store;
        if (mem_ready) begin
          if (is_store) begin
            PCWr    = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        RUWr    = 1'b1;
        PCWr    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      state_d   = S_FETCH;
      MemReq    = 1'b0;
      MemIsData = 1'b0;
      IRWr      = 1'b0;
      PCWr      = 1'b0;
      RUWr      = 1'b0;
      DMWr      = 1'b0;
      retire    = 1'b0;
    end
  end

  // Retire counter, wraps naturally at 2^32
  always_comb begin
    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign State   = state_q;
  assign Instret = instret_q;

`ifdef ILLEGAL_TRAP_EN
  assign Trap = (state_q == S_TRAP);
`else
  assign Trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with hand-computed expectations.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  OpCode;
  logic        mem_ready;
  logic        MemReq, MemIsData, IRWr, PCWr, RUWr, DMWr, Trap;
  logic [2:0]  State;
  logic [31:0] Instret;

  int n_chk  = 0;
  int n_fail = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .mem_ready(mem_ready),
    .MemReq(MemReq), .MemIsData(MemIsData), .IRWr(IRWr), .PCWr(PCWr),
    .RUWr(RUWr), .DMWr(DMWr), .State(State), .Instret(Instret), .Trap(Trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Runs one instruction starting in FETCH. mem_ready is low for the first
  // mem_stall MEM cycles and high otherwise. Stops on return to FETCH or on TRAP.
  task automatic run_instr(input logic [6:0] op, input int mem_stall,
                           output int cyc, output int irwr_n, output int pcwr_n,
                           output int ruwr_n, output int dmwr_n, output int dmwr_bad,
                           output int memdata_n);
    int stalls;
    bit done;
    stalls = mem_stall;
    cyc = 0; irwr_n = 0; pcwr_n = 0; ruwr_n = 0; dmwr_n = 0; dmwr_bad = 0; memdata_n = 0;
    done = 1'b0;
    OpCode = op;
    for (int i = 0; i < 40 && !done; i++) begin
      if (State == 3'd3 && stalls > 0) begin
        mem_ready = 1'b0;
        stalls--;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      cyc++;
      if (IRWr) irwr_n++;
      if (PCWr) pcwr_n++;
      if (RUWr) ruwr_n++;
      if (DMWr) dmwr_n++;
      if (DMWr && State != 3'd3) dmwr_bad++;
      if (MemReq && MemIsData) memdata_n++;
      step();
      if (State == 3'd0 || State == 3'd5) done = 1'b1;
    end
    if (!done) chk("run_timeout", 32'd1, 32'd0);
    mem_ready = 1'b0;
  endtask

  int cyc, irwr_n, pcwr_n, ruwr_n, dmwr_n, dmwr_bad, memdata_n;
  logic [31:0] base;

  initial begin
    rst = 1'b1;
    OpCode = 7'b0110011;
    mem_ready = 1'b1;
    step();
    step();
    // Reset cycle: mem_ready high, but everything masked
    chk("rst_state",   State,   32'd0);
    chk("rst_instret", Instret, 32'd0);
    chk("rst_memreq",  MemReq,  32'd0);
    chk("rst_irwr",    IRWr,    32'd0);
    chk("rst_pcwr",    PCWr,    32'd0);
    chk("rst_trap",    Trap,    32'd0);

    // add, mem_ready high: 0,1,2,4 explicitly
    rst = 1'b0;
    #1;
    chk("add_c1_state",  State,  32'd0);
    chk("add_c1_memreq", MemReq, 32'd1);
    chk("add_c1_isdata", MemIsData, 32'd0);
    chk("add_c1_irwr",   IRWr,   32'd1);
    step();
    chk("add_c2_state",  State,  32'd1);
    chk("add_c2_memreq", MemReq, 32'd0);
    step();
    chk("add_c3_state",  State,  32'd2);
    step();
    chk("add_c4_state",  State,  32'd4);
    chk("add_c4_ruwr",   RUWr,   32'd1);
    chk("add_c4_pcwr",   PCWr,   32'd1);
    step();
    chk("add_done_state",   State,   32'd0);
    chk("add_instret",      Instret, 32'd1);
    mem_ready = 1'b0;
    #1;
    chk("fetch_wait_irwr", IRWr, 32'd0);

    // load, 3 stall cycles in MEM
    run_instr(7'b0000011, 3, cyc, irwr_n, pcwr_n, ruwr_n, dmwr_n, dmwr_bad, memdata_n);
    chk("ld_cycles",  cyc,       32'd8);
    chk("ld_memdata", memdata_n, 32'd4);
    chk("ld_ruwr",    ruwr_n,    32'd1);
    chk("ld_pcwr",    pcwr_n,    32'd1);
    chk("ld_dmwr",    dmwr_n,    32'd0);
    chk("ld_instret", Instret,   32'd2);

    // store then beq from a fresh reset
    do_reset();
    run_instr(7'b0100011, 0, cyc, irwr_n, pcwr_n, ruwr_n, dmwr_n, dmwr_bad, memdata_n);
    chk("st_cycles", cyc,      32'd4);
    chk("st_dmwr",   dmwr_n,   32'd1);
    chk("st_dmwr_outside", dmwr_bad, 32'd0);
    chk("st_ruwr",   ruwr_n,   32'd0);
    chk("st_pcwr",   pcwr_n,   32'd1);
    run_instr(7'b1100011, 0, cyc, irwr_n, pcwr_n, ruwr_n, dmwr_n, dmwr_bad, memdata_n);
    chk("br_cycles",  cyc,     32'd3);
    chk("br_ruwr",    ruwr_n,  32'd0);
    chk("br_pcwr",    pcwr_n,  32'd1);
    chk("br_memdata", memdata_n, 32'd0);
    chk("stbr_instret", Instret, 32'd2);

    // jal and lui take the WB path
    run_instr(7'b1101111, 0, cyc, irwr_n, pcwr_n, ruwr_n, dmwr_n, dmwr_bad, memdata_n);
    chk("jal_cycles", cyc,    32'd4);
    chk("jal_ruwr",   ruwr_n, 32'd1);
    run_instr(7'b0110111, 0, cyc, irwr_n, pcwr_n, ruwr_n, dmwr_n, dmwr_bad, memdata_n);
    chk("lui_cycles", cyc,    32'd4);
    chk("lui_irwr",   irwr_n, 32'd1);
    chk("lui_instret", Instret, 32'd4);

    // unlisted opcode 0000000
    base = Instret;
    run_instr(7'b0000000, 0, cyc, irwr_n, pcwr_n, ruwr_n, dmwr_n, dmwr_bad, memdata_n);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_state",   State,   32'd5);
    chk("ill_trap",    Trap,    32'd1);
    chk("ill_instret", Instret, base);
    chk("ill_pcwr",    pcwr_n,  32'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("trap_hold_state",  State, 32'd5);
      chk("trap_hold_strobe", {MemReq, IRWr, PCWr, RUWr, DMWr}, 32'd0);
    end
    do_reset();
    chk("trap_cleared", Trap, 32'd0);
    base = 32'd0;
`else
    chk("nop_cycles",  cyc,     32'd2);
    chk("nop_pcwr",    pcwr_n,  32'd1);
    chk("nop_instret", Instret, base + 32'd1);
    chk("nop_trap",    Trap,    32'd0);
`endif

    // counter wrap via a preloaded value while idling in FETCH
    do_reset();
    force dut.instret_q = 32'hFFFF_FFFF;
    step();
    release dut.instret_q;
    #1;
    chk("wrap_preload", Instret, 32'hFFFF_FFFF);
    run_instr(7'b0010011, 0, cyc, irwr_n, pcwr_n, ruwr_n, dmwr_n, dmwr_bad, memdata_n);
    chk("wrap_instret", Instret, 32'd0);

    // rst arriving in MEM together with mem_ready
    do_reset();
    OpCode = 7'b0100011;
    mem_ready = 1'b1;
    step();
    step();
    step();
    chk("mid_mem_state", State, 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_mem_pcwr",   PCWr,   32'd0);
    chk("mid_mem_memreq", MemReq, 32'd0);
    chk("mid_mem_dmwr",   DMWr,   32'd0);
    step();
    chk("mid_mem_after_state",   State,   32'd0);
    chk("mid_mem_after_instret", Instret, 32'd0);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("post_rst_memreq", MemReq, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL provide clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL provide rst, input, 1, synchronous active-high reset sampled on rising clk.
REQ-003 SHALL provide OpCode, input, 7, opcode field of the instruction register.
REQ-004 SHALL provide mem_ready, input, 1, shared memory completion handshake for fetch and data access.
REQ-005 SHALL provide MemReq, output, 1, memory request, held high until mem_ready is seen.
REQ-006 SHALL provide MemIsData, output, 1, port select: 0 = instruction fetch address (PC), 1 = data address (ALU result).
REQ-007 SHALL provide IRWr, output, 1, instruction register load strobe.
REQ-008 SHALL provide PCWr, output, 1, PC update strobe.
REQ-009 SHALL provide RUWr, output, 1, register file write strobe.
REQ-010 SHALL provide DMWr, output, 1, data memory write qualifier.
REQ-011 SHALL provide State, output, 3, current state encoding.
REQ-012 SHALL provide Instret, output, 32, retired-instruction counter.
REQ-013 SHALL provide Trap, output, 1, illegal-opcode halt flag (Configuration only).

Function
REQ-014 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to FETCH next cycle.
REQ-015 FETCH SHALL assert MemReq, MemIsData=0; on mem_ready it SHALL pulse IRWr and go to DECODE, else remain in FETCH.
REQ-016 DECODE SHALL last exactly one cycle and go to EXEC for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111, 0110111, 0010111.
REQ-017 EXEC for 0000011 (load) or 0100011 (store) SHALL go to MEM; for 1100011 (branch) it SHALL pulse PCWr, count a retire, and go to FETCH; for all other legal opcodes it SHALL go to WB.
REQ-018 MEM SHALL assert MemReq, MemIsData=1, DMWr=1 for stores only; it SHALL remain until mem_ready, then a load goes to WB and a store pulses PCWr, counts a retire, and goes to FETCH.
REQ-019 WB SHALL pulse RUWr and PCWr for one cycle, count a retire, and go to FETCH.
REQ-020 All strobes (IRWr, PCWr, RUWr) SHALL be single-cycle pulses, combinationally decoded from State, OpCode and mem_ready; DMWr SHALL be high only while in MEM for a store.
REQ-021 Latency with mem_ready tied high SHALL be: R/I/U/jal/jalr 4 cycles, load 5, store 4, branch 3.
REQ-022 Instret SHALL increment by 1 on each retire and wrap from 0xFFFFFFFF to 0.
REQ-023 MemReq SHALL never be asserted outside FETCH and MEM; mem_ready in any other state SHALL be ignored.

Reset
REQ-024 rst SHALL force State=FETCH and Instret=0 and clear Trap on the next edge, overriding any pending mem_ready.
REQ-025 During and after the rst edge all strobes and MemReq SHALL be 0 in the reset cycle; FETCH begins on the first cycle with rst low.
REQ-026 rst asserted mid-MEM SHALL abandon the access without a retire or a PCWr.

Configuration
REQ-027 With ILLEGAL_TRAP_EN defined, DECODE of any opcode not listed in REQ-016 SHALL go to TRAP, assert Trap=1, and stay there with all strobes 0 until rst.
REQ-028 Without ILLEGAL_TRAP_EN, an unlisted opcode SHALL be treated as a NOP: DECODE pulses PCWr, counts a retire, and goes to FETCH; Trap SHALL be tied to 0.

Verification
REQ-029 Reset, then add (0110011) with mem_ready=1 -> states 0,1,2,4; RUWr and PCWr high in cycle 4; Instret=1.
REQ-030 Load (0000011) with mem_ready low for 3 MEM cycles -> MemReq=1 and MemIsData=1 for 4 cycles; RUWr in WB; total 8 cycles.
REQ-031 Store followed by beq -> DMWr only in MEM; branch retires in 3 cycles; RUWr never asserted; Instret=2.
REQ-032 Opcode 0000000 -> with ILLEGAL_TRAP_EN: State=5, Trap=1, Instret unchanged; without it: PCWr in DECODE, Instret+1.
REQ-033 Preload Instret to 0xFFFFFFFF via 2^32-cycle-equivalent force, then retire one instruction -> Instret=0.
REQ-034 rst asserted in MEM with mem_ready=1 in the same cycle -> State=FETCH next, no PCWr, Instret=0.
